// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 frame driver:
//   - state_t         : frame sequencer states
//   - GRB_*_MSB       : bit offsets of the G/R/B bytes inside a 24-bit pixel
//   - DEF_*           : default timing for a 50 MHz clock
//   - scale_channel() : 8-bit channel brightness scaling, (ch*(level+1))>>8
// Optional feature macro used by the top level: WS2812_BRIGHTNESS_SCALE_EN
// ---------------------------------------------------------------------------
package ws2812_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_STALL,
        ST_LATCH
    } state_t;

    localparam int GRB_G_MSB = 23;
    localparam int GRB_R_MSB = 15;
    localparam int GRB_B_MSB = 7;

    localparam int DEF_NUM_LEDS  = 110;
    localparam int DEF_BIT_CLK   = 63;     // 1.26 us
    localparam int DEF_T0H_CLK   = 20;     // 0.40 us
    localparam int DEF_T1H_CLK   = 40;     // 0.80 us
    localparam int DEF_RESET_CLK = 15000;  // 300 us

    // level=255 is an exact passthrough, level=0 gives black.
    function automatic logic [7:0] scale_channel(input logic [7:0] ch,
                                                 input logic [7:0] level);
        logic [16:0] prod;
        prod = {9'd0, ch} * {8'd0, ({1'b0, level} + 9'd1)};
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ---------------------------------------------------------------------------
// ws2812_bit_encoder
// Produces one WS2812 bit waveform per start strobe: high for T1H_CLK (bit=1)
// or T0H_CLK (bit=0) cycles, then low until BIT_CLK cycles have elapsed.
// A new start in the same cycle as bit_done continues with no gap.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a bit period on the next cycle
//   bit_value   : value of the bit being started
//   line_out    : registered serial line
//   bit_done    : high in the last cycle of the current bit period
// ---------------------------------------------------------------------------
module ws2812_bit_encoder #(
    parameter int BIT_CLK = 63,
    parameter int T0H_CLK = 20,
    parameter int T1H_CLK = 40,
    parameter int CNT_W   = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_value,
    output logic line_out,
    output logic bit_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CLK - 1);
    localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CLK);
    localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CLK);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] th_q, th_d;
    logic             line_q, line_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        th_d     = th_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            th_d     = bit_value ? T1H : T0H;
        end else if (active_q) begin
            if (cnt_q == LAST_CNT) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Line is computed from next-state values so the registered output
        // lines up with the counter it describes.
        line_d = active_d && (cnt_d < th_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            th_q     <= '0;
            line_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            th_q     <= th_d;
            line_q   <= line_d;
        end
    end

    assign line_out = line_q;
    assign bit_done = active_q && (cnt_q == LAST_CNT);

endmodule

// File: rtl/ws2812_frame_driver.sv
// ---------------------------------------------------------------------------
// ws2812_frame_driver
// Pulls NUM_LEDS 24-bit GRB pixels over valid/ready and serialises them MSB
// first onto a WS2812 line, then holds the line low for RESET_CLK cycles and
// pulses frame_done.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   frame_start   : start a frame (accepted only in IDLE)
//   pixel_grb     : pixel data {G,R,B}
//   pixel_valid   : pixel_grb valid
//   brightness    : per-pixel scale, present only with WS2812_BRIGHTNESS_SCALE_EN
//   pixel_ready   : driver accepts a pixel this cycle
//   led_index     : index of the pixel being requested
//   leds_line     : WS2812 serial data
//   busy          : frame in progress
//   frame_done    : one-cycle pulse at end of latch gap
//   underrun_err  : sticky pixel-starvation flag, cleared by next frame_start
// Optional feature macro: WS2812_BRIGHTNESS_SCALE_EN
// ---------------------------------------------------------------------------
module ws2812_frame_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS  = DEF_NUM_LEDS,
    parameter int BIT_CLK   = DEF_BIT_CLK,
    parameter int T0H_CLK   = DEF_T0H_CLK,
    parameter int T1H_CLK   = DEF_T1H_CLK,
    parameter int RESET_CLK = DEF_RESET_CLK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [23:0] pixel_grb,
    input  logic        pixel_valid,
`ifdef WS2812_BRIGHTNESS_SCALE_EN
    input  logic [7:0]  brightness,
`endif
    output logic        pixel_ready,
    output logic [6:0]  led_index,
    output logic        leds_line,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun_err
);

    localparam int MAX_CLK = (BIT_CLK > RESET_CLK) ? BIT_CLK : RESET_CLK;
    localparam int CNT_W   = $clog2(MAX_CLK + 1);
    localparam int RC_W    = $clog2(NUM_LEDS + 1);

    localparam logic [RC_W-1:0]  NUM_CNT    = RC_W'(NUM_LEDS);
    localparam logic [6:0]       LAST_IDX   = 7'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(RESET_CLK - 1);

    if (!(T0H_CLK > 0 && T0H_CLK < T1H_CLK && T1H_CLK < BIT_CLK)) begin : g_bad_timing
        $error("ws2812_frame_driver: need 0 < T0H_CLK < T1H_CLK < BIT_CLK");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 128) begin : g_bad_num_leds
        $error("ws2812_frame_driver: NUM_LEDS must be 1..128 (7-bit led_index)");
    end

    state_t           state_q, state_d;
    logic [23:0]      shift_q, shift_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [23:0]      hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [RC_W-1:0]  req_cnt_q, req_cnt_d;     // pixels accepted this frame
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             underrun_q, underrun_d;
    logic             frame_done_q, frame_done_d;

    logic        enc_start;
    logic        enc_bit;
    logic        enc_done;
    logic        xfer;
    logic [23:0] load_data;

`ifdef WS2812_BRIGHTNESS_SCALE_EN
    // brightness is applied as the pixel moves from holding to shift register.
    assign load_data = {scale_channel(hold_q[GRB_G_MSB -: 8], brightness),
                        scale_channel(hold_q[GRB_R_MSB -: 8], brightness),
                        scale_channel(hold_q[GRB_B_MSB -: 8], brightness)};
`else
    assign load_data = hold_q;
`endif

    assign busy        = (state_q != ST_IDLE);
    assign pixel_ready = busy && !hold_full_q && (req_cnt_q < NUM_CNT);
    assign xfer        = pixel_valid && pixel_ready;
    assign led_index   = (req_cnt_q >= NUM_CNT) ? LAST_IDX : 7'(req_cnt_q);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        req_cnt_d    = req_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        underrun_d   = underrun_q;
        frame_done_d = 1'b0;
        enc_start    = 1'b0;
        enc_bit      = shift_q[22];

        // Transfers only happen while holding is empty; loads only while it
        // is full, so the two never touch hold_full in the same cycle.
        if (xfer) begin
            hold_d      = pixel_grb;
            hold_full_d = 1'b1;
            req_cnt_d   = req_cnt_q + RC_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d     = ST_FETCH;
                    req_cnt_d   = '0;
                    underrun_d  = 1'b0;
                    hold_full_d = 1'b0;
                end
            end
            ST_FETCH, ST_STALL: begin
                if (state_q == ST_STALL) begin
                    underrun_d = 1'b1;
                end
                if (hold_full_q) begin
                    shift_d     = load_data;
                    bit_cnt_d   = 5'd23;
                    hold_full_d = 1'b0;
                    enc_start   = 1'b1;
                    enc_bit     = load_data[23];
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (enc_done) begin
                    if (bit_cnt_q != 5'd0) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        enc_start = 1'b1;
                        enc_bit   = shift_q[22];
                    end else if (hold_full_q) begin
                        shift_d     = load_data;
                        bit_cnt_d   = 5'd23;
                        hold_full_d = 1'b0;
                        enc_start   = 1'b1;
                        enc_bit     = load_data[23];
                    end else if (req_cnt_q < NUM_CNT) begin
                        state_d    = ST_STALL;
                        underrun_d = 1'b1;
                    end else begin
                        state_d   = ST_LATCH;
                        lat_cnt_d = '0;
                    end
                end
            end
            ST_LATCH: begin
                if (lat_cnt_q == LATCH_LAST) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            req_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            req_cnt_q    <= req_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            underrun_q   <= underrun_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done   = frame_done_q;
    assign underrun_err = underrun_q;

    ws2812_bit_encoder #(
        .BIT_CLK (BIT_CLK),
        .T0H_CLK (T0H_CLK),
        .T1H_CLK (T1H_CLK),
        .CNT_W   (CNT_W)
    ) u_bit_encoder (
        .clk       (clk),
        .reset     (reset),
        .start     (enc_start),
        .bit_value (enc_bit),
        .line_out  (leds_line),
        .bit_done  (enc_done)
    );

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// ---------------------------------------------------------------------------
// tb_ws2812_frame_driver
// Drives frames from a vector table, decodes leds_line pulse widths back into
// pixels and compares them with a queue of expected pixels pushed on every
// valid&&ready transfer. Hand-written sequences cover reset and mid-frame abort.
// ---------------------------------------------------------------------------
module tb_ws2812_frame_driver;

    localparam int NUM_LEDS  = 2;
    localparam int BIT_CLK   = 10;
    localparam int T0H_CLK   = 3;
    localparam int T1H_CLK   = 7;
    localparam int RESET_CLK = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [23:0] pixel_grb = '0;
    logic        pixel_valid = 1'b0;
`ifdef WS2812_BRIGHTNESS_SCALE_EN
    logic [7:0]  tb_bright = 8'd255;
`endif
    logic        pixel_ready;
    logic [6:0]  led_index;
    logic        leds_line;
    logic        busy;
    logic        frame_done;
    logic        underrun_err;

    always #5 clk = ~clk;

    ws2812_frame_driver #(
        .NUM_LEDS  (NUM_LEDS),
        .BIT_CLK   (BIT_CLK),
        .T0H_CLK   (T0H_CLK),
        .T1H_CLK   (T1H_CLK),
        .RESET_CLK (RESET_CLK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .pixel_grb    (pixel_grb),
        .pixel_valid  (pixel_valid),
`ifdef WS2812_BRIGHTNESS_SCALE_EN
        .brightness   (tb_bright),
`endif
        .pixel_ready  (pixel_ready),
        .led_index    (led_index),
        .leds_line    (leds_line),
        .busy         (busy),
        .frame_done   (frame_done),
        .underrun_err (underrun_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] exp_pixel(input logic [23:0] p);
`ifdef WS2812_BRIGHTNESS_SCALE_EN
        int g, r, b;
        g = (int'(p[23:16]) * (int'(tb_bright) + 1)) >> 8;
        r = (int'(p[15:8])  * (int'(tb_bright) + 1)) >> 8;
        b = (int'(p[7:0])   * (int'(tb_bright) + 1)) >> 8;
        return {g[7:0], r[7:0], b[7:0]};
`else
        return p;
`endif
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [23:0] exp_q[$];
    logic [23:0] bit_acc;
    int  nbits       = 0;
    int  hi_len      = 0;
    int  last_hi     = 0;
    int  low_len     = 0;
    int  since_rise  = 0;
    int  rise_cnt    = 0;
    int  done_cnt    = 0;
    int  frame_xfers = 0;
    bit  rise_seen   = 1'b0;
    bit  prev_line   = 1'b0;
    bit  no_stall    = 1'b1;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            nbits = 0; hi_len = 0; low_len = 0; since_rise = 0;
            rise_seen = 1'b0; prev_line = 1'b0; frame_xfers = 0;
        end else begin
            if (frame_start && !busy) begin
                frame_xfers = 0;
                rise_seen   = 1'b0;
            end
            if (!busy || frame_xfers == NUM_LEDS)
                chk("ready_idle_latch", 32'(pixel_ready), 32'd0);
            if (pixel_valid && pixel_ready) begin
                chk("led_index", 32'(led_index), 32'(frame_xfers));
                exp_q.push_back(exp_pixel(pixel_grb));
                frame_xfers++;
            end
            if (leds_line) begin
                if (!prev_line) begin
                    if (rise_seen && (nbits != 0 || no_stall))
                        chk("bit_period", 32'(since_rise), 32'(BIT_CLK));
                    rise_seen  = 1'b1;
                    since_rise = 0;
                    hi_len     = 0;
                    rise_cnt++;
                end
                hi_len++;
                low_len = 0;
            end else begin
                if (prev_line) begin
                    last_hi = hi_len;
                    if (hi_len == T1H_CLK)      bit_acc = {bit_acc[22:0], 1'b1};
                    else if (hi_len == T0H_CLK) bit_acc = {bit_acc[22:0], 1'b0};
                    else chk("pulse_width", 32'(hi_len), 32'(T0H_CLK));
                    nbits++;
                    if (nbits == 24) begin
                        nbits = 0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_pixel", 32'(bit_acc), 32'hFFFFFFFF);
                        end else begin
                            chk("pixel_data", 32'(bit_acc), 32'(exp_q.pop_front()));
                        end
                    end
                end
                low_len++;
            end
            since_rise++;
            if (frame_done) begin
                done_cnt++;
                chk("latch_low_len", 32'(low_len), 32'(BIT_CLK - last_hi + RESET_CLK + 1));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            prev_line = leds_line;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [23:0] pix0;
        logic [23:0] pix1;
        int          gap;        // cycles pixel_valid stays low after pixel 0
        bit          spam;       // pulse frame_start repeatedly while busy
        int          bright;
        bit          exp_underrun;
    } vec_t;

`ifdef WS2812_BRIGHTNESS_SCALE_EN
    localparam int NV = 4;
`else
    localparam int NV = 3;
`endif
    vec_t vecs[NV];

    task automatic run_frame(input vec_t v, input int id);
        int d0;
        int pix_i;
        int gap_left;
        d0       = done_cnt;
        pix_i    = 0;
        gap_left = 0;
        no_stall = (v.gap == 0);
`ifdef WS2812_BRIGHTNESS_SCALE_EN
        tb_bright = v.bright[7:0];
`endif
        @(posedge clk); #1;
        frame_start = 1'b1;
        pixel_valid = 1'b1;
        pixel_grb   = v.pix0;
        for (int cyc = 0; cyc < 3000 && done_cnt == d0; cyc++) begin
            @(negedge clk);
            if (pixel_valid && pixel_ready) begin
                pix_i++;
                if (pix_i == 1) gap_left = v.gap;
            end
            @(posedge clk); #1;
            frame_start = v.spam && (cyc < 400) && (cyc % 5 == 2);
            if (cyc == 0) chk("underrun_cleared", 32'(underrun_err), 32'd0);
            if (gap_left > 0) begin
                pixel_valid = 1'b0;
                gap_left--;
            end else begin
                pixel_valid = 1'b1;
                pixel_grb   = (pix_i == 0) ? v.pix0 : (pix_i == 1) ? v.pix1 : 24'hDEAD5A;
            end
        end
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("frame_done_count", 32'(done_cnt - d0), 32'd1);
        chk("xfers_per_frame", 32'(frame_xfers), 32'(NUM_LEDS));
        chk("underrun_err", 32'(underrun_err), 32'(v.exp_underrun));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        $display("frame %0d: pix0=%06h pix1=%06h gap=%0d spam=%0d done=%0d xfers=%0d underrun=%0d",
                 id, v.pix0, v.pix1, v.gap, v.spam, done_cnt - d0, frame_xfers, underrun_err);
    endtask

    initial begin
        int r0, d0;
        vecs[0] = '{pix0: 24'hFF0000, pix1: 24'h000001, gap: 0,   spam: 1'b0, bright: 255, exp_underrun: 1'b0};
        vecs[1] = '{pix0: 24'hA5C33C, pix1: 24'h5A0F81, gap: 272, spam: 1'b0, bright: 255, exp_underrun: 1'b1};
        vecs[2] = '{pix0: 24'h123456, pix1: 24'hFEDCBA, gap: 0,   spam: 1'b1, bright: 255, exp_underrun: 1'b0};
`ifdef WS2812_BRIGHTNESS_SCALE_EN
        vecs[3] = '{pix0: 24'hFF8040, pix1: 24'hFF8040, gap: 0,   spam: 1'b0, bright: 127, exp_underrun: 1'b0};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_leds_line",    32'(leds_line),    32'd0);
        chk("rst_pixel_ready",  32'(pixel_ready),  32'd0);
        chk("rst_led_index",    32'(led_index),    32'd0);
        chk("rst_busy",         32'(busy),         32'd0);
        chk("rst_frame_done",   32'(frame_done),   32'd0);
        chk("rst_underrun_err", 32'(underrun_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_frame(vecs[i], i);

        // Mid-frame reset during bit 10 of pixel 0.
        no_stall = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b1;
        pixel_valid = 1'b1;
        pixel_grb   = 24'hC3A55A;
        @(posedge clk); #1;
        frame_start = 1'b0;
        r0 = rise_cnt;
        for (int c = 0; c < 500 && (rise_cnt - r0) < 11; c++) @(negedge clk);
        chk("reach_bit10", 32'(rise_cnt - r0), 32'd11);
        d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        pixel_valid = 1'b0;
        @(negedge clk);
        chk("abort_leds_line", 32'(leds_line), 32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        r0 = rise_cnt;
        repeat (600) @(posedge clk);
        @(negedge clk);
        chk("abort_no_done",  32'(done_cnt - d0), 32'd0);
        chk("abort_no_rises", 32'(rise_cnt - r0), 32'd0);
        $display("abort: line=%0d busy=%0d done_pulses=%0d", leds_line, busy, done_cnt - d0);

        run_frame(vecs[0], NV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_driver.md
Name: ws2812_frame_driver

Overview:
Downstream serial stage of the racer game core. Pulls one 24-bit GRB pixel per LED from the frame generator over a valid/ready handshake and serialises the frame onto the single WS2812 data line (leds_line). After the last bit it drives a latch/reset gap, then pulses frame_done. One instance per LED strip, clocked from the 50 MHz board clock.

Parameters:
NUM_LEDS, 110, LEDs per frame (positions 0..109)
BIT_CLK, 63, clocks per bit period (1.26 us at 50 MHz)
T0H_CLK, 20, high time for a 0 bit (0.40 us)
T1H_CLK, 40, high time for a 1 bit (0.80 us)
RESET_CLK, 15000, latch gap in clocks (300 us)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
frame_start  input  1  one-cycle request to send a frame; honoured only in IDLE
pixel_grb  input  24  pixel data; [23:16]=G, [15:8]=R, [7:0]=B
pixel_valid  input  1  pixel_grb is valid
pixel_ready  output  1  driver accepts a pixel this cycle
led_index  output  7  index of the pixel being requested (0..NUM_LEDS-1)
leds_line  output  1  WS2812 serial data
busy  output  1  frame in progress (not IDLE)
frame_done  output  1  one-cycle pulse when the latch gap ends
underrun_err  output  1  sticky; set on pixel starvation, cleared by the next accepted frame_start

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset values: leds_line=0, pixel_ready=0, led_index=0, busy=0, frame_done=0, underrun_err=0. State returns to IDLE.
- Reset mid-frame aborts the frame immediately. The line is low from the next edge. No frame_done pulse.
- States: IDLE, FETCH, SHIFT, STALL, LATCH.
- IDLE: line low. frame_start moves to FETCH, clears led_index and underrun_err, and sets busy on the next cycle. frame_start is ignored in any other state.
- Double buffer: 24-bit shift register plus a 24-bit holding register with a full flag.
- pixel_ready = busy && !hold_full && (pixels requested < NUM_LEDS). A transfer happens on valid&&ready; it loads the holding register and increments led_index. led_index saturates at NUM_LEDS-1 once the last pixel is taken.
- FETCH: wait for holding full, move holding to shift, enter SHIFT. The first edge goes high 1 cycle later.
- SHIFT: bits go out MSB first (G7 first). Each bit lasts BIT_CLK cycles. Line is high for cycles 0..TxH-1 of the bit, low for the remainder. The bit counter runs 23..0.
- At the end of bit 0:
  - if holding full: reload and continue with no gap (back-to-back bit periods);
  - else if pixels remain: STALL;
  - else: LATCH.
- STALL: line low, underrun_err set. On holding full, reload and return to SHIFT.
- LATCH: line low for exactly RESET_CLK cycles. Then frame_done pulses 1 cycle and the state returns to IDLE (busy low in the same cycle as frame_done).
- frame_start in the same cycle as frame_done-to-IDLE is ignored; it is only accepted when already in IDLE.
- Parameter rule: 0 < T0H_CLK < T1H_CLK < BIT_CLK, checked by elaboration assertions. The counter width is sized from max(BIT_CLK, RESET_CLK).

Optional Feature:
WS2812_BRIGHTNESS_SCALE_EN: adds input port brightness[7:0]. Each channel is scaled as (ch*(brightness+1))>>8 when loaded into the shift register. brightness=255 gives passthrough and 0 gives black. brightness is sampled per pixel at load.
Without the macro: no port, data is sent unmodified, and there is no multiplier logic.

Decomposition:
- Package ws2812_pkg holds:
  - state enum;
  - GRB field offset constants;
  - default timing constants for 50 MHz (BIT, T0H, T1H, RESET).
- Sub-module ws2812_bit_encoder: takes bit_value and a start strobe, and produces line_out and bit_done after BIT_CLK cycles. The top-level FSM owns buffering and sequencing.

Test Plan:
All scenarios use NUM_LEDS=2, BIT_CLK=10, T0H=3, T1H=7, RESET_CLK=20.
1. frame_start with pixel_valid always high, pixels 0xFF0000 and 0x000001 -> 48 back-to-back bit periods; first 8 high for 7 cycles, next 39 high for 3, last high for 7; then 20 low cycles; frame_done pulses once; underrun_err=0.
2. Hold pixel_valid low for 30 cycles after the first pixel's last bit -> line low throughout STALL, underrun_err=1; resumes the correct second pixel when valid returns; underrun_err clears on the next frame_start.
3. Assert reset during bit 10 of pixel 0 -> leds_line=0 and busy=0 on the next edge; frame_done never pulses; a new frame_start sends a full correct frame.
4. Pulse frame_start repeatedly while busy -> exactly one frame sent; led_index sequence 0,1; exactly two pixel transfers.
5. Check handshake: count valid&&ready transfers -> exactly NUM_LEDS per frame; pixel_ready=0 in IDLE and LATCH.
6. With WS2812_BRIGHTNESS_SCALE_EN, brightness=127, pixel 0xFF8040 -> transmitted bits encode 0x7F4020.
